// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the multiply/divide issue
//               controller and the fixed-latency M-extension unit.
//               - md_tag_t   : in-flight tag {valid, rd} carried alongside the
//                              unit's pipeline
//               - wb_entry_t : buffered writeback entry {rd, data}
//               - FUNCT3_*   : M-op selects shared with the unit
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

   localparam int MD_XLEN = 32;
   localparam int MD_REGW = 5;

   typedef struct packed {
      logic               valid;
      logic [MD_REGW-1:0] rd;
   } md_tag_t;

   typedef struct packed {
      logic [MD_REGW-1:0] rd;
      logic [MD_XLEN-1:0] data;
   } wb_entry_t;

   localparam logic [2:0] FUNCT3_MUL    = 3'b000;
   localparam logic [2:0] FUNCT3_MULH   = 3'b001;
   localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
   localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
   localparam logic [2:0] FUNCT3_DIV    = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
   localparam logic [2:0] FUNCT3_REM    = 3'b110;
   localparam logic [2:0] FUNCT3_REMU   = 3'b111;

endpackage
`default_nettype wire

// File: rtl/muldiv_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_wb_fifo
// Description : Synchronous in-order FIFO of wb_entry_t with registered
//               storage and an occupancy count. Head is read straight from
//               the storage flops, so it is stable until popped.
// Ports       : clk_i, rst_ni (async, active-low)
//               push_i / push_data_i : write one entry
//               pop_i                : consume head (only while valid_o)
//               head_o / valid_o     : oldest entry and its presence
//               count_o              : number of stored entries
// Config      : MULDIV_PROTOCOL_CHECK_EN adds an overflow assertion.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_wb_fifo
   import muldiv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  wb_entry_t                  push_data_i,
   input  logic                       pop_i,
   output wb_entry_t                  head_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = $clog2(DEPTH + 1);

   wb_entry_t            r_mem [DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_cnt_w-1:0]   r_count;

   // Storage is reset too so that the head outputs read as zero in reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push_i) begin
            r_mem[r_wr_ptr] <= push_data_i;
            r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
         end
         if (pop_i) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({push_i, pop_i})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign head_o  = r_mem[r_rd_ptr];
   assign valid_o = (r_count != '0);
   assign count_o = r_count;

`ifdef MULDIV_PROTOCOL_CHECK_EN
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(push_i && !pop_i && (r_count == c_cnt_w'(DEPTH))));
      end
   end
`endif

endmodule
`default_nettype wire

// File: rtl/muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_issue_ctrl
// Description : Execute-stage initiator for the fixed-latency mul/div unit.
//               Issues decoded M-ops, tracks pending destinations in a
//               scoreboard, stalls decode on RAW/WAW hazards or lack of
//               writeback credit, and buffers returning results in a FIFO
//               drained onto the register-file writeback port.
// Ports       : clk_i, rst_ni (async, active-low)
//               id_*        : decoded instruction and forwarded operands
//               stall_o     : hold decode this cycle
//               md_*_o      : issue strobe, funct3 and operands to the unit
//               md_result_i, md_valid_i : unit return
//               wb_*        : writeback request with valid/ready handshake
//               busy_o      : any op in flight or buffered
//               err_o       : sticky protocol error (macro builds only)
// Config      : MULDIV_PROTOCOL_CHECK_EN adds err_o and protocol assertions.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_issue_ctrl
   import muldiv_pkg::*;
#(
   parameter int XLEN     = MD_XLEN,   // must match the package widths
   parameter int REGW     = MD_REGW,
   parameter int LATENCY  = 2,
   parameter int WB_DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            id_valid_i,
   input  logic            id_is_muldiv_i,
   input  logic [2:0]      id_funct3_i,
   input  logic [REGW-1:0] id_rs1_i,
   input  logic [REGW-1:0] id_rs2_i,
   input  logic            id_rs1_used_i,
   input  logic            id_rs2_used_i,
   input  logic [REGW-1:0] id_rd_i,
   input  logic            id_rd_we_i,
   input  logic [XLEN-1:0] id_op1_i,
   input  logic [XLEN-1:0] id_op2_i,
   output logic            stall_o,
   output logic            md_issue_o,
   output logic [2:0]      md_funct3_o,
   output logic [XLEN-1:0] md_in1_o,
   output logic [XLEN-1:0] md_in2_o,
   input  logic [XLEN-1:0] md_result_i,
   input  logic            md_valid_i,
   output logic            wb_valid_o,
   output logic [REGW-1:0] wb_rd_o,
   output logic [XLEN-1:0] wb_data_o,
   input  logic            wb_ready_i,
   output logic            busy_o
`ifdef MULDIV_PROTOCOL_CHECK_EN
   ,
   output logic            err_o
`endif
);

   localparam int c_cnt_w  = $clog2(LATENCY + WB_DEPTH + 1);
   localparam int c_fcnt_w = $clog2(WB_DEPTH + 1);

   logic [2**REGW-1:0]  r_pend;
   md_tag_t             r_tag [LATENCY];

   logic                w_raw;
   logic                w_waw;
   logic                w_credit_ok;
   logic                w_issue;
   logic                w_push;
   logic                w_pop;
   logic [c_cnt_w-1:0]  w_inflight;
   logic [c_fcnt_w-1:0] w_fifo_count;
   logic                w_fifo_valid;
   wb_entry_t           w_push_data;
   wb_entry_t           w_head;

   // ---------------- hazard / credit / issue ----------------
   assign w_raw = (id_rs1_used_i && r_pend[id_rs1_i]) ||
                  (id_rs2_used_i && r_pend[id_rs2_i]);
   assign w_waw = id_rd_we_i && r_pend[id_rd_i];

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         w_inflight = w_inflight + c_cnt_w'(r_tag[i].valid);
      end
   end

   // Every op, including rd=x0, reserves a FIFO slot at issue; a pop in the
   // current cycle does not free credit until the next one.
   assign w_credit_ok = (w_inflight + c_cnt_w'(w_fifo_count)) < c_cnt_w'(WB_DEPTH);

   assign stall_o = id_valid_i && (w_raw || w_waw || (id_is_muldiv_i && !w_credit_ok));

   // Decode keeps driving during reset, so the issue path is masked by
   // rst_ni to hold every unit-facing output at zero.
   assign w_issue     = rst_ni && id_valid_i && id_is_muldiv_i && !stall_o;
   assign md_issue_o  = w_issue;
   assign md_funct3_o = {3{rst_ni}} & id_funct3_i;
   assign md_in1_o    = {XLEN{rst_ni}} & id_op1_i;
   assign md_in2_o    = {XLEN{rst_ni}} & id_op2_i;

   // ---------------- tag pipe ----------------
   // Mirrors the unit's pipeline: the tail lines up with md_valid_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_tag[0] <= '{valid: w_issue, rd: id_rd_i};
         for (int i = 1; i < LATENCY; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   // ---------------- scoreboard ----------------
   // Clear and set never target the same rd in one cycle (WAW stall), so the
   // two writes are independent.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pend <= '0;
      end else begin
         if (w_pop) begin
            r_pend[w_head.rd] <= 1'b0;
         end
         if (w_issue && (id_rd_i != '0)) begin
            r_pend[id_rd_i] <= 1'b1;
         end
      end
   end

   // ---------------- return path / writeback FIFO ----------------
   // Results for x0 are discarded here and never reach the writeback port.
   assign w_push      = md_valid_i && (r_tag[LATENCY-1].rd != '0);
   assign w_push_data = '{rd: r_tag[LATENCY-1].rd, data: md_result_i};
   assign w_pop       = w_fifo_valid && wb_ready_i;

   muldiv_wb_fifo #(
      .DEPTH (WB_DEPTH)
   ) u_wb_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (w_push),
      .push_data_i (w_push_data),
      .pop_i       (w_pop),
      .head_o      (w_head),
      .valid_o     (w_fifo_valid),
      .count_o     (w_fifo_count)
   );

   assign wb_valid_o = w_fifo_valid;
   assign wb_rd_o    = w_head.rd;
   assign wb_data_o  = w_head.data;
   assign busy_o     = (w_inflight != '0) || (w_fifo_count != '0);

`ifdef MULDIV_PROTOCOL_CHECK_EN
   // ---------------- protocol checking ----------------
   logic r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err <= 1'b0;
      end else if (md_valid_i != r_tag[LATENCY-1].valid) begin
         r_err <= 1'b1;
      end
   end

   assign err_o = r_err;

   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(md_valid_i && !r_tag[LATENCY-1].valid));
         assert (!(!md_valid_i && r_tag[LATENCY-1].valid));
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_issue_ctrl
// Description : Self-checking bench for muldiv_issue_ctrl. A behavioural
//               fixed-latency unit answers issues; a driver pushes the
//               hand-computed expected writeback for every issued op into a
//               queue and a monitor pops/compares on each wb handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_issue_ctrl;
   import muldiv_pkg::*;

   localparam int XLEN     = 32;
   localparam int REGW     = 5;
   localparam int LATENCY  = 2;
   localparam int WB_DEPTH = 4;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            id_valid_i, id_is_muldiv_i;
   logic [2:0]      id_funct3_i;
   logic [REGW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
   logic            id_rs1_used_i, id_rs2_used_i, id_rd_we_i;
   logic [XLEN-1:0] id_op1_i, id_op2_i;
   logic            stall_o, md_issue_o;
   logic [2:0]      md_funct3_o;
   logic [XLEN-1:0] md_in1_o, md_in2_o, md_result_i;
   logic            md_valid_i;
   logic            wb_valid_o, wb_ready_i, busy_o;
   logic [REGW-1:0] wb_rd_o;
   logic [XLEN-1:0] wb_data_o;
`ifdef MULDIV_PROTOCOL_CHECK_EN
   logic            err_o;
`endif

   muldiv_issue_ctrl #(
      .XLEN(XLEN), .REGW(REGW), .LATENCY(LATENCY), .WB_DEPTH(WB_DEPTH)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .id_valid_i(id_valid_i), .id_is_muldiv_i(id_is_muldiv_i),
      .id_funct3_i(id_funct3_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
      .id_rd_i(id_rd_i), .id_rd_we_i(id_rd_we_i),
      .id_op1_i(id_op1_i), .id_op2_i(id_op2_i),
      .stall_o(stall_o), .md_issue_o(md_issue_o), .md_funct3_o(md_funct3_o),
      .md_in1_o(md_in1_o), .md_in2_o(md_in2_o),
      .md_result_i(md_result_i), .md_valid_i(md_valid_i),
      .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
      .wb_ready_i(wb_ready_i), .busy_o(busy_o)
`ifdef MULDIV_PROTOCOL_CHECK_EN
      , .err_o(err_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_issue  = 0;

   always @(posedge clk_i) cyc <= cyc + 1;
   always @(negedge clk_i) if (rst_ni && md_issue_o) n_issue++;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event", nm);
   endtask

   // ---------------- behavioural fixed-latency unit ----------------
   function automatic logic [31:0] unit_f(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [63:0] p;
      case (f)
         FUNCT3_MUL:   return a * b;
         FUNCT3_MULH:  begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         FUNCT3_MULHU: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         FUNCT3_DIV:   return (b == 0) ? '1 : 32'($signed(a) / $signed(b));
         default:      return '0;
      endcase
   endfunction

   typedef struct packed {
      logic        v;
      logic [31:0] r;
   } u_t;
   u_t          up [LATENCY];
   logic        cap_v = 1'b0;
   logic [31:0] cap_r = '0;
   logic        inj = 1'b0;

   always @(negedge clk_i) begin
      cap_v = md_issue_o;
      cap_r = unit_f(md_funct3_o, md_in1_o, md_in2_o);
   end

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < LATENCY; i++) up[i] <= '0;
      end else begin
         up[0] <= '{cap_v, cap_r};
         for (int i = 1; i < LATENCY; i++) up[i] <= up[i-1];
      end
   end

   assign md_valid_i  = up[LATENCY-1].v | inj;
   assign md_result_i = inj ? 32'hDEAD_BEEF : up[LATENCY-1].r;

   // ---------------- writeback monitor ----------------
   always @(negedge clk_i) begin
      if (rst_ni && wb_valid_o && wb_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wb_unexpected actual=rd%0d/%0h required=none", wb_rd_o, wb_data_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wb_rd", 64'(wb_rd_o), 64'(e.rd));
            chk("wb_data", 64'(wb_data_o), 64'(e.data));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_cycle(input int k);
      while (cyc < k) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic issue_op(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expv, output int t);
      bit ok = 0;
      t = -1;
      id_valid_i = 1; id_is_muldiv_i = 1; id_funct3_i = f3;
      id_rs1_i = 5'd1; id_rs2_i = 5'd2; id_rs1_used_i = 1; id_rs2_used_i = 1;
      id_rd_i = rd; id_rd_we_i = 1; id_op1_i = a; id_op2_i = b;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk_i);
         if (!stall_o) begin
            ok = 1;
            t  = cyc;
            chk("md_issue", 64'(md_issue_o), 64'(1));
            chk("md_in1", 64'(md_in1_o), 64'(a));
            chk("md_in2", 64'(md_in2_o), 64'(b));
            chk("md_funct3", 64'(md_funct3_o), 64'(f3));
            if (rd != 0) exp_q.push_back('{rd, expv});
         end
         @(posedge clk_i);
         #1;
      end
      id_valid_i = 0; id_is_muldiv_i = 0;
      if (!ok) fail_now("issue_timeout");
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk_i);
         if (!busy_o && exp_q.size() == 0) ok = 1;
      end
      if (!ok) fail_now("idle_timeout");
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_reset_outputs();
      chk("rst_stall", 64'(stall_o), 0);
      chk("rst_md_issue", 64'(md_issue_o), 0);
      chk("rst_md_funct3", 64'(md_funct3_o), 0);
      chk("rst_md_in1", 64'(md_in1_o), 0);
      chk("rst_md_in2", 64'(md_in2_o), 0);
      chk("rst_wb_valid", 64'(wb_valid_o), 0);
      chk("rst_wb_rd", 64'(wb_rd_o), 0);
      chk("rst_wb_data", 64'(wb_data_o), 0);
      chk("rst_busy", 64'(busy_o), 0);
`ifdef MULDIV_PROTOCOL_CHECK_EN
      chk("rst_err", 64'(err_o), 0);
`endif
   endtask

   task automatic drive_live_muldiv();
      id_valid_i = 1; id_is_muldiv_i = 1; id_funct3_i = 3'b101;
      id_rs1_i = 5'd3; id_rs2_i = 5'd4; id_rs1_used_i = 1; id_rs2_used_i = 1;
      id_rd_i = 5'd9; id_rd_we_i = 1;
      id_op1_i = 32'hAAAA_AAAA; id_op2_i = 32'h5555_5555;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   // ---------------- directed tests ----------------
   initial begin
      int t1, t2, tr, nst, tacc, s, base, r, t5, tdummy, tp;
      bit ok;

      // Reset state with decode actively presenting an M-op
      wb_ready_i = 1;
      drive_live_muldiv();
      #2;
      check_reset_outputs();
      repeat (2) @(posedge clk_i);
      #1;
      id_valid_i = 0; id_is_muldiv_i = 0;
      rst_ni = 1;

      // Back-to-back independent MUL / MULH
      issue_op(FUNCT3_MUL, 5'd5, 32'd3, 32'd4, 32'd12, t1);
      issue_op(FUNCT3_MULH, 5'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, t2);
      chk("t1_consecutive_issue", 64'(t2), 64'(t1 + 1));
      ok = 0; tr = -1;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk_i);
         if (wb_valid_o) begin ok = 1; tr = cyc; end
      end
      chk("t1_wb_latency", 64'(tr), 64'(t1 + LATENCY + 1));
      wait_idle();

      // RAW: DIV x7 then ADD reading x7
      issue_op(FUNCT3_DIV, 5'd7, 32'd20, 32'd3, 32'd6, t1);
      id_valid_i = 1; id_is_muldiv_i = 0; id_rs1_i = 5'd7; id_rs1_used_i = 1;
      id_rs2_i = 5'd0; id_rs2_used_i = 0; id_rd_i = 5'd8; id_rd_we_i = 1;
      nst = 0; ok = 0; tacc = -1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk_i);
         if (stall_o) begin
            nst++;
            chk("t2_no_issue_in_stall", 64'(md_issue_o), 0);
         end else begin
            ok = 1; tacc = cyc;
         end
         @(posedge clk_i);
         #1;
      end
      id_valid_i = 0;
      chk("t2_stall_cycles", 64'(nst), 64'(3));
      chk("t2_proceed_cycle", 64'(tacc), 64'(t1 + 4));
      wait_idle();

      // Credit limit: 5 ops offered with writeback blocked
      wb_ready_i = 0;
      s = cyc; base = n_issue; r = -1; t5 = -1;
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               issue_op(FUNCT3_MUL, 5'(10 + k), 32'(k + 1), 32'd2, 32'(2 * (k + 1)), tdummy);
               if (k == 4) t5 = tdummy;
            end
         end
         begin
            wait_cycle(s + 10);
            @(negedge clk_i);
            chk("t3_issued_under_backpressure", 64'(n_issue - base), 64'(4));
            chk("t3_fifth_stalled", 64'(stall_o), 64'(1));
            chk("t3_wb_valid_held", 64'(wb_valid_o), 64'(1));
            @(posedge clk_i);
            #1;
            r = cyc;
            wb_ready_i = 1;
         end
      join
      chk("t3_fifth_issue_after_pop", 64'(t5), 64'(r + 1));
      wait_idle();

      // MUL to x0: issued, never written back, no scoreboard entry
      issue_op(FUNCT3_MUL, 5'd0, 32'd5, 32'd5, 32'd25, t1);
      id_valid_i = 1; id_is_muldiv_i = 0; id_rs1_i = 5'd0; id_rs1_used_i = 1;
      id_rs2_used_i = 0; id_rd_i = 5'd0; id_rd_we_i = 1;
      @(negedge clk_i);
      chk("t4_x0_no_hazard", 64'(stall_o), 0);
      chk("t4_busy_c1", 64'(busy_o), 1);
      chk("t4_no_wb_c1", 64'(wb_valid_o), 0);
      @(posedge clk_i);
      #1;
      id_valid_i = 0;
      @(negedge clk_i);
      chk("t4_busy_c2", 64'(busy_o), 1);
      chk("t4_no_wb_c2", 64'(wb_valid_o), 0);
      @(negedge clk_i);
      chk("t4_busy_c3", 64'(busy_o), 0);
      chk("t4_no_wb_c3", 64'(wb_valid_o), 0);
      @(posedge clk_i);
      #1;

      // Reset with two ops in flight and one buffered
      wb_ready_i = 0;
      issue_op(FUNCT3_MUL, 5'd20, 32'd2, 32'd3, 32'd6, t1);
      issue_op(FUNCT3_MUL, 5'd21, 32'd2, 32'd4, 32'd8, tdummy);
      issue_op(FUNCT3_MUL, 5'd22, 32'd2, 32'd5, 32'd10, tdummy);
      drive_live_muldiv();
      #1;
      chk("t5_busy_before_reset", 64'(busy_o), 1);
      rst_ni = 0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      repeat (2) @(posedge clk_i);
      #1;
      id_valid_i = 0; id_is_muldiv_i = 0;
      rst_ni = 1;
      wb_ready_i = 1;
      inj = 1;
      @(posedge clk_i);
      #1;
      inj = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk("t5_no_push_after_reset", 64'(wb_valid_o), 0);
      end
`ifdef MULDIV_PROTOCOL_CHECK_EN
      chk("t5_err_sticky", 64'(err_o), 1);
`endif
      @(posedge clk_i);
      #1;

      // Simultaneous push and pop at count 2
      wb_ready_i = 0;
      issue_op(FUNCT3_MUL, 5'd24, 32'd7, 32'd3, 32'd21, tp);
      issue_op(FUNCT3_MULHU, 5'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, tdummy);
      issue_op(FUNCT3_DIV, 5'd26, 32'hFFFF_FFEC, 32'd4, 32'hFFFF_FFFB, tdummy);
      wait_cycle(tp + 4);
      wb_ready_i = 1;
      @(negedge clk_i);
      chk("t6_count_before", 64'(dut.u_wb_fifo.count_o), 64'(2));
      chk("t6_push_same_cycle", 64'(md_valid_i), 64'(1));
      @(posedge clk_i);
      #1;
      wb_ready_i = 0;
      @(negedge clk_i);
      chk("t6_count_after", 64'(dut.u_wb_fifo.count_o), 64'(2));
      chk("t6_head_rd", 64'(wb_rd_o), 64'(25));
      @(posedge clk_i);
      #1;
      wb_ready_i = 1;
      wait_idle();

      chk("final_queue_empty", 64'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
